// File: rtl/scan_transfer_ctrl_if.sv
// Outbound word link of scan_transfer_ctrl: a valid/ready handshake carrying
// the source scanner and the word index within the current drain.
interface scan_transfer_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic             out_src;
    logic [CNT_W-1:0] out_index;

    modport master (
        output out_valid,
        output out_src,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_src,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/scan_transfer_ctrl.sv
// Ping-pong drain controller for scanners A/B: start_scan forwarding, round-robin grant,
// word streaming. Defining XFER_TIMEOUT_EN adds a stall-timeout abort.
module scan_transfer_ctrl #(
    parameter int BUF_DEPTH = 100,
    parameter int CNT_W     = 8
`ifdef XFER_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 255
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy_a,
    input  logic rdy_b,
    input  logic second_a,
    input  logic second_b,
    output logic transfer_a,
    output logic transfer_b,
    output logic start_scan_a,
    output logic start_scan_b,
    output logic xfer_done,
    output logic abort,
    scan_transfer_ctrl_if.master link
);

    typedef enum logic [1:0] {
        IDLE,
        XFER_A,
        XFER_B,
        GAP
    } state_t;

    state_t           state;
    logic             last_served;
    logic [CNT_W-1:0] cnt;
    logic             second_a_q;
    logic             second_b_q;
    logic             stall_hit;
    logic             owner_rdy;
    logic             accept;
    logic             last_word;

    assign accept          = link.out_valid & link.out_ready;
    assign owner_rdy       = (state == XFER_B) ? rdy_b : rdy_a;
    assign last_word       = (cnt == CNT_W'(BUF_DEPTH - 1));
    assign link.out_index  = cnt;

`ifdef XFER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_cnt;

    // Consecutive stalled XFER cycles; the one that reaches TIMEOUT takes the abort path.
    assign stall_hit = link.out_valid & ~link.out_ready &
                       (stall_cnt == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !link.out_valid || link.out_ready) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_served    <= 1'b1;
            cnt            <= '0;
            second_a_q     <= 1'b0;
            second_b_q     <= 1'b0;
            transfer_a     <= 1'b0;
            transfer_b     <= 1'b0;
            start_scan_a   <= 1'b0;
            start_scan_b   <= 1'b0;
            xfer_done      <= 1'b0;
            abort          <= 1'b0;
            link.out_valid <= 1'b0;
            link.out_src   <= 1'b0;
        end else begin
            // Each scanner's second-buffer edge kicks off its partner, whatever the FSM is doing.
            second_a_q   <= second_a;
            second_b_q   <= second_b;
            start_scan_b <= second_a & ~second_a_q;
            start_scan_a <= second_b & ~second_b_q;
            xfer_done    <= 1'b0;
            abort        <= 1'b0;

            case (state)
                IDLE: begin
                    if (rdy_a && (!rdy_b || last_served)) begin
                        state          <= XFER_A;
                        transfer_a     <= 1'b1;
                        link.out_valid <= 1'b1;
                        link.out_src   <= 1'b0;
                    end else if (rdy_b) begin
                        state          <= XFER_B;
                        transfer_b     <= 1'b1;
                        link.out_valid <= 1'b1;
                        link.out_src   <= 1'b1;
                    end
                end

                XFER_A, XFER_B: begin
                    // Abort outranks completion, even when the last word is accepted in the same cycle.
                    if (!owner_rdy || stall_hit || (accept && last_word)) begin
                        state          <= GAP;
                        abort          <= !owner_rdy || stall_hit;
                        xfer_done      <= owner_rdy && !stall_hit;
                        last_served    <= (state == XFER_B);
                        cnt            <= '0;
                        transfer_a     <= 1'b0;
                        transfer_b     <= 1'b0;
                        link.out_valid <= 1'b0;
                        link.out_src   <= 1'b0;
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                GAP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_transfer_ctrl.sv
// Self-checking bench for scan_transfer_ctrl: directed vectors, a drain-level reference
// model compared every cycle, and hand-computed literal checkpoints.
module tb_scan_transfer_ctrl;

    localparam int BUF_DEPTH = 100;
    localparam int CNT_W     = 8;
`ifdef XFER_TIMEOUT_EN
    localparam int TIMEOUT    = 4;
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam int TIMEOUT    = 255;
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rdy_a;
    logic rdy_b;
    logic second_a;
    logic second_b;
    logic transfer_a;
    logic transfer_b;
    logic start_scan_a;
    logic start_scan_b;
    logic xfer_done;
    logic abort;

    scan_transfer_ctrl_if #(.CNT_W(CNT_W)) link ();

    scan_transfer_ctrl #(
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
`ifdef XFER_TIMEOUT_EN
        ,
        .TIMEOUT   (TIMEOUT)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy_a        (rdy_a),
        .rdy_b        (rdy_b),
        .second_a     (second_a),
        .second_b     (second_b),
        .transfer_a   (transfer_a),
        .transfer_b   (transfer_b),
        .start_scan_a (start_scan_a),
        .start_scan_b (start_scan_b),
        .xfer_done    (xfer_done),
        .abort        (abort),
        .link         (link)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Drain-level model: who owns the link, how many words it has delivered, cool-down pending.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_last  = 1;
    int m_words = 0;
    int m_stall = 0;
    bit m_prev_sa = 1'b0;
    bit m_prev_sb = 1'b0;
    bit m_start_a = 1'b0;
    bit m_start_b = 1'b0;
    bit m_done    = 1'b0;
    bit m_abort   = 1'b0;

    int accepted = 0;
    int pulses_b = 0;
    int order[$];
    bit ta_prev = 1'b0;
    bit tb_prev = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ra, input logic rb,
                                 input logic sa, input logic sb, input logic ordy, input int n);
        rst            = r;
        rdy_a          = ra;
        rdy_b          = rb;
        second_a       = sa;
        second_b       = sb;
        link.out_ready = ordy;
        tick(n);
    endtask

    task automatic resetPulse();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    endtask

    always @(posedge clk) begin : model
        bit owner_rdy;
        if (rst) begin
            m_owner = -1; m_gap = 1'b0; m_last = 1; m_words = 0; m_stall = 0;
            m_prev_sa = 1'b0; m_prev_sb = 1'b0;
            m_start_a = 1'b0; m_start_b = 1'b0; m_done = 1'b0; m_abort = 1'b0;
        end else begin
            m_start_b = second_a && !m_prev_sa;
            m_start_a = second_b && !m_prev_sb;
            m_prev_sa = second_a;
            m_prev_sb = second_b;
            m_done    = 1'b0;
            m_abort   = 1'b0;
            if (m_owner >= 0) begin
                owner_rdy = (m_owner == 1) ? rdy_b : rdy_a;
                m_stall   = link.out_ready ? 0 : m_stall + 1;
                if (!owner_rdy || (TIMEOUT_ON && m_stall >= TIMEOUT)) begin
                    m_abort = 1'b1;
                    m_last  = m_owner; m_owner = -1; m_gap = 1'b1; m_words = 0;
                end else if (link.out_ready) begin
                    m_words++;
                    if (m_words == BUF_DEPTH) begin
                        m_done = 1'b1;
                        m_last = m_owner; m_owner = -1; m_gap = 1'b1; m_words = 0;
                    end
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (rdy_a || rdy_b) begin
                if (rdy_a && rdy_b) m_owner = (m_last == 0) ? 1 : 0;
                else                m_owner = rdy_a ? 0 : 1;
                m_stall = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("transfer_a",   transfer_a,     (m_owner == 0));
            checkOutput("transfer_b",   transfer_b,     (m_owner == 1));
            checkOutput("out_valid",    link.out_valid, (m_owner >= 0));
            checkOutput("out_src",      link.out_src,   (m_owner == 1));
            checkOutput("out_index",    link.out_index, m_words);
            checkOutput("xfer_done",    xfer_done,      m_done);
            checkOutput("abort",        abort,          m_abort);
            checkOutput("start_scan_a", start_scan_a,   m_start_a);
            checkOutput("start_scan_b", start_scan_b,   m_start_b);
            checkOutput("mutex",        transfer_a & transfer_b, 1'b0);
        end
        if (link.out_valid && link.out_ready) accepted++;
        if (start_scan_b) pulses_b++;
        if (transfer_a && !ta_prev) order.push_back(0);
        if (transfer_b && !tb_prev) order.push_back(1);
        ta_prev = transfer_a;
        tb_prev = transfer_b;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        check_en = 1'b1;
        checkOutput("reset transfer_a", transfer_a, 0);
        checkOutput("reset out_valid", link.out_valid, 0);
        checkOutput("reset out_index", link.out_index, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // Single full drain of A.
        accepted = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("t1 grant transfer_a", transfer_a, 1);
        checkOutput("t1 first index", link.out_index, 0);
        tick(99);
        checkOutput("t1 last index", link.out_index, 99);
        tick(1);
        checkOutput("t1 xfer_done", xfer_done, 1);
        checkOutput("t1 gap transfer_a", transfer_a, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("t1 done one cycle", xfer_done, 0);
        tick(2);
        checkOutput("t1 accepted", accepted, 100);

        // Simultaneous ready: A first, then alternation.
        resetPulse();
        order.delete();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 310);
        checkOutput("t2 grant count", order.size(), 4);
        if (order.size() >= 3) begin
            checkOutput("t2 first A", order[0], 0);
            checkOutput("t2 second B", order[1], 1);
            checkOutput("t2 third A", order[2], 0);
        end
        checkOutput("t2 B owns at end", transfer_b, 1);
        resetPulse();

        // Start forwarding.
        pulses_b = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("t3 start_scan_b pulse", start_scan_b, 1);
        tick(1);
        checkOutput("t3 start_scan_b single", start_scan_b, 0);
        tick(8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        checkOutput("t3 second pulse b", start_scan_b, 1);
        checkOutput("t3 pulse a", start_scan_a, 1);
        tick(1);
        checkOutput("t3 pulse count", pulses_b, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // Backpressure during a B drain.
        resetPulse();
        accepted = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("t4 grant transfer_b", transfer_b, 1);
        checkOutput("t4 out_src", link.out_src, 1);
        tick(5);
        checkOutput("t4 index before stall", link.out_index, 5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("t4 index stall 1", link.out_index, 5);
        tick(1);
        checkOutput("t4 index stall 2", link.out_index, 5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 95);
        checkOutput("t4 xfer_done", xfer_done, 1);
        checkOutput("t4 accepted", accepted, 100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);

        // Abort mid-drain.
        resetPulse();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        tick(40);
        checkOutput("t5 index 40", link.out_index, 40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("t5 abort", abort, 1);
        checkOutput("t5 transfer_a low", transfer_a, 0);
        checkOutput("t5 no done", xfer_done, 0);
        tick(2);

        // Abort on the final word beats completion.
        resetPulse();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        tick(99);
        checkOutput("t5b index 99", link.out_index, 99);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("t5b abort", abort, 1);
        checkOutput("t5b no done", xfer_done, 0);
        tick(2);

        // Reset in the middle of a drain.
        resetPulse();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        tick(60);
        checkOutput("t6 index 60", link.out_index, 60);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        checkOutput("t6 rst transfer_a", transfer_a, 0);
        checkOutput("t6 rst out_valid", link.out_valid, 0);
        checkOutput("t6 rst out_index", link.out_index, 0);
        checkOutput("t6 rst xfer_done", xfer_done, 0);
        checkOutput("t6 rst abort", abort, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        // Stalled link: timeout abort if built in, otherwise an indefinite wait.
        resetPulse();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("t7 grant", transfer_a, 1);
`ifdef XFER_TIMEOUT_EN
        tick(3);
        checkOutput("t7 no abort yet", abort, 0);
        checkOutput("t7 still draining", transfer_a, 1);
        tick(1);
        checkOutput("t7 timeout abort", abort, 1);
        checkOutput("t7 transfer dropped", transfer_a, 0);
`else
        tick(1000);
        checkOutput("t7 still draining", transfer_a, 1);
        checkOutput("t7 still valid", link.out_valid, 1);
        checkOutput("t7 index held", link.out_index, 0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
